gb_cpu_interrupt_ctrl: RTL and testbench
========================================

Name: gb_cpu_interrupt_ctrl

Overview:
- Interrupt controller and sequencer for the CPU core.
- Owns IE/IF, IME, the EI delay slot and HALT entry/exit.
- Raises the ISR request into the instruction decoder at instruction boundaries, then supplies the vector and clears the serviced IF bit when the ISR acknowledges.
- Sits between the peripheral IRQ lines / bus register decode and the decoder/control unit.

Parameters:
- NUM_IRQ, 5, number of interrupt sources (bit0 VBlank .. bit4 Joypad; bit0 highest priority).
- VECTOR_BASE, 8'h40, vector of source 0.
- VECTOR_STRIDE, 8, vector spacing between sources.

Ports:
- clk  in  1  system clock; one clock domain. Reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- irq_req  in  NUM_IRQ  one-cycle request pulses from peripherals; set IF bits.
- ie_we  in  1  write strobe for IE (0xFFFF).
- if_we  in  1  write strobe for IF (0xFF0F).
- reg_wdata  in  8  write data for IE/IF.
- ie_rdata  out  8  IE readback.
- if_rdata  out  8  IF readback; bits [7:NUM_IRQ] read 1.
- instr_boundary  in  1  pulse in the last M-cycle of every instruction.
- ei_exec  in  1  EI executing; coincident with its instr_boundary.
- di_exec  in  1  DI executing.
- reti_exec  in  1  RETI executing.
- halt_exec  in  1  HALT executing; coincident with its instr_boundary.
- isr_ack  in  1  ISR vector-select M-cycle strobe.
- isr_cmd  out  1  to decoder: next instruction is the ISR.
- isr_vector  out  8  jump target, valid the cycle after isr_ack.
- ime  out  1  interrupt master enable.
- halted  out  1  CPU halted; the fetch stalls while high.
- halt_bug  out  1  one-cycle pulse: the next fetch must not increment PC.

Behaviour:
- Reset values:
  - IE=0, IF=0, ime=0, ei_pending=0.
  - isr_cmd=0, isr_vector=8'h00, halted=0, halt_bug=0.
  - State = RUN.
- pending = IE[NUM_IRQ-1:0] & IF[NUM_IRQ-1:0].
- IF update order within a cycle:
  1. if_we write.
  2. Ack clear.
  3. OR of irq_req.
  - A request on the same bit as a clear or write therefore stays set.
- IE stores all 8 bits.
- IME handling:
  - ei_exec sets ei_pending. At the next instr_boundary, ei_pending moves to ime.
  - The dispatch check uses ime_eff = ime | ei_pending, so the interrupt is taken after exactly one following instruction.
  - di_exec clears ime and ei_pending immediately; it overrides an ei_pending set in the same or an earlier cycle.
  - reti_exec sets ime immediately, with no delay.
- States: RUN, HALT, DISPATCH.
- RUN:
  - On instr_boundary with ime_eff and pending!=0 → DISPATCH.
  - Else on halt_exec:
    - If !ime_eff and pending!=0: halt bug. Pulse halt_bug for 1 cycle and stay in RUN.
    - Otherwise → HALT.
- HALT:
  - halted=1, registered, asserted the cycle after halt_exec.
  - When pending!=0: go → DISPATCH if ime, else → RUN. halted deasserts on that transition.
  - Wake latency is 1 cycle after IF is set.
- DISPATCH:
  - ime cleared and ei_pending cleared on entry; isr_cmd=1 from the entry cycle until isr_ack.
  - On isr_ack, re-sample pending:
    - Lowest set bit n: clear IF[n], isr_vector = VECTOR_BASE + n*VECTOR_STRIDE.
    - pending==0 (IE rewritten during the push): isr_vector=8'h00, no IF clear.
  - Return to RUN.
- isr_vector holds its value until the next ack.
- Simultaneous events:
  - halt_exec and a dispatch condition on the same boundary: dispatch wins; HALT is not entered.
  - ie_we/if_we during DISPATCH are permitted and affect the ack sample.
- An asynchronous reset mid-DISPATCH or mid-HALT returns to the reset values immediately.

Optional Feature:
- Macro GB_CPU_HALT_BUG_EN.
- Defined: the halt bug is emulated as above.
- Undefined: halt_bug is tied to 0. HALT with !ime_eff and pending!=0 is a no-op; the state stays RUN.

Decomposition:
- Add to gb_cpu_common_pkg:
  - irq_src_t enum (VBLANK, STAT, TIMER, SERIAL, JOYPAD).
  - int_state_t enum (RUN, HALT, DISPATCH).
  - IRQ vector constants.
- One sub-module, gb_cpu_irq_priority: combinational lowest-bit encoder producing valid, index and one-hot clear mask.

Test Plan:
- Priority: IE=0x1F, ime=1, irq_req=5'b10100, instr_boundary → isr_cmd=1; then isr_ack → isr_vector=0x50, IF=0xF0, ime=0.
- EI delay: ime=0, IF=0x01, IE=0x01. EI boundary, then NOP boundary → dispatch at the NOP boundary, not at EI's; with DI between them → isr_cmd stays 0.
- Halt wake: ime=0, IE=0x04, halt_exec → halted=1; irq_req=5'b00100 → halted=0 one cycle later, no isr_cmd, IF=0xE4.
- Halt bug: ime=0, IE=IF=0x02, halt_exec → halt_bug pulse and halted stays 0. With the macro undefined → no pulse, halted stays 0.
- Ack cancel: in DISPATCH, ie_we with data 0x00 before isr_ack → isr_vector=0x00, IF unchanged.
- Collision: isr_ack clearing bit0 in the same cycle as irq_req[0] → IF[0] remains 1; async rst_n low mid-DISPATCH → isr_cmd=0, IE=IF=0.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared CPU types: interrupt sources, sequencer states, vectors
package gb_cpu_common_pkg;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_src_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALT     = 2'd1,
        DISPATCH = 2'd2
    } int_state_t;

    localparam int          IRQ_COUNT      = 5;
    localparam logic [7:0]  IRQ_VEC_BASE   = 8'h40;
    localparam int          IRQ_VEC_STRIDE = 8;
    localparam logic [7:0]  VEC_VBLANK     = 8'h40;
    localparam logic [7:0]  VEC_STAT       = 8'h48;
    localparam logic [7:0]  VEC_TIMER      = 8'h50;
    localparam logic [7:0]  VEC_SERIAL     = 8'h58;
    localparam logic [7:0]  VEC_JOYPAD     = 8'h60;

endpackage

// File: rtl/gb_cpu_irq_priority.sv
// rtl/gb_cpu_irq_priority.sv - lowest-set-bit encoder for pending interrupts
module gb_cpu_irq_priority #(
    parameter int N = 5
) (
    input  logic [N-1:0] pending,
    output logic         valid,
    output logic [2:0]   index,
    output logic [N-1:0] clear_mask
);

    // Scan from the top down so the lowest set bit (highest priority) wins
    always_comb begin
        valid      = 1'b0;
        index      = 3'd0;
        clear_mask = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                valid      = 1'b1;
                index      = 3'(i);
                clear_mask = '0;
                clear_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// rtl/gb_cpu_interrupt_ctrl.sv - IE/IF, IME, EI delay, HALT and ISR dispatch sequencer (GB_CPU_HALT_BUG_EN enables halt-bug emulation)
module gb_cpu_interrupt_ctrl
    import gb_cpu_common_pkg::*;
#(
    parameter int         NUM_IRQ       = IRQ_COUNT,
    parameter logic [7:0] VECTOR_BASE   = IRQ_VEC_BASE,
    parameter int         VECTOR_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               ie_we,
    input  logic               if_we,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         ie_rdata,
    output logic [7:0]         if_rdata,
    input  logic               instr_boundary,
    input  logic               ei_exec,
    input  logic               di_exec,
    input  logic               reti_exec,
    input  logic               halt_exec,
    input  logic               isr_ack,
    output logic               isr_cmd,
    output logic [7:0]         isr_vector,
    output logic               ime,
    output logic               halted,
    output logic               halt_bug
);

    int_state_t         state_q, state_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic               ime_q, ime_d;
    logic               ei_pending_q, ei_pending_d;
    logic [7:0]         isr_vector_q, isr_vector_d;
    logic               halt_bug_q, halt_bug_d;

    logic [NUM_IRQ-1:0] pending;
    logic               pending_any;
    logic               ime_eff;
    logic               prio_valid;
    logic [2:0]         prio_index;
    logic [NUM_IRQ-1:0] prio_mask;
    logic [NUM_IRQ-1:0] ack_clear;

    assign pending     = ie_q[NUM_IRQ-1:0] & if_q;
    assign pending_any = |pending;
    assign ime_eff     = ime_q | ei_pending_q;

    gb_cpu_irq_priority #(
        .N (NUM_IRQ)
    ) u_priority (
        .pending    (pending),
        .valid      (prio_valid),
        .index      (prio_index),
        .clear_mask (prio_mask)
    );

    // Next-state for the sequencer, IME/EI delay slot, IE/IF and the vector register
    always_comb begin
        state_d      = state_q;
        ie_d         = ie_q;
        ime_d        = ime_q;
        ei_pending_d = ei_pending_q;
        isr_vector_d = isr_vector_q;
        halt_bug_d   = 1'b0;
        ack_clear    = '0;

        if (ie_we) begin
            ie_d = reg_wdata;
        end

        // EI takes effect one boundary late; DI beats any EI still in flight
        if (instr_boundary && ei_pending_q) begin
            ime_d        = 1'b1;
            ei_pending_d = 1'b0;
        end
        if (ei_exec) begin
            ei_pending_d = 1'b1;
        end
        if (reti_exec) begin
            ime_d = 1'b1;
        end
        if (di_exec) begin
            ime_d        = 1'b0;
            ei_pending_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (instr_boundary && ime_eff && pending_any) begin
                    state_d      = DISPATCH;
                    ime_d        = 1'b0;
                    ei_pending_d = 1'b0;
                end else if (halt_exec) begin
                    if (ime_eff || !pending_any) begin
                        state_d = HALT;
                    end
`ifdef GB_CPU_HALT_BUG_EN
                    else begin
                        halt_bug_d = 1'b1;
                    end
`endif
                end
            end
            HALT: begin
                if (pending_any) begin
                    if (ime_q) begin
                        state_d      = DISPATCH;
                        ime_d        = 1'b0;
                        ei_pending_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DISPATCH: begin
                // Pending is re-sampled here: IE/IF writes during the push count
                if (isr_ack) begin
                    state_d = RUN;
                    if (prio_valid) begin
                        isr_vector_d = VECTOR_BASE + 8'(VECTOR_STRIDE * int'(prio_index));
                        ack_clear    = prio_mask;
                    end else begin
                        isr_vector_d = 8'h00;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // Write, then ack clear, then new requests: a fresh request always survives
        if_d = if_we ? reg_wdata[NUM_IRQ-1:0] : if_q;
        if_d = if_d & ~ack_clear;
        if_d = if_d | irq_req;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            ie_q         <= 8'h00;
            if_q         <= '0;
            ime_q        <= 1'b0;
            ei_pending_q <= 1'b0;
            isr_vector_q <= 8'h00;
            halt_bug_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ie_q         <= ie_d;
            if_q         <= if_d;
            ime_q        <= ime_d;
            ei_pending_q <= ei_pending_d;
            isr_vector_q <= isr_vector_d;
            halt_bug_q   <= halt_bug_d;
        end
    end

    // Readback with unimplemented IF bits reading as 1
    always_comb begin
        if_rdata              = 8'hFF;
        if_rdata[NUM_IRQ-1:0] = if_q;
    end

    assign ie_rdata   = ie_q;
    assign isr_cmd    = (state_q == DISPATCH);
    assign halted     = (state_q == HALT);
    assign isr_vector = isr_vector_q;
    assign ime        = ime_q;
    assign halt_bug   = halt_bug_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// tb/tb_gb_cpu_interrupt_ctrl.sv - table-driven scoreboard bench for gb_cpu_interrupt_ctrl
module tb_gb_cpu_interrupt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] irq_req = '0;
    logic       ie_we = 1'b0, if_we = 1'b0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] ie_rdata, if_rdata;
    logic       instr_boundary = 1'b0, ei_exec = 1'b0, di_exec = 1'b0;
    logic       reti_exec = 1'b0, halt_exec = 1'b0, isr_ack = 1'b0;
    logic       isr_cmd, ime, halted, halt_bug;
    logic [7:0] isr_vector;

    always #5 clk = ~clk;

    gb_cpu_interrupt_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_req        (irq_req),
        .ie_we          (ie_we),
        .if_we          (if_we),
        .reg_wdata      (reg_wdata),
        .ie_rdata       (ie_rdata),
        .if_rdata       (if_rdata),
        .instr_boundary (instr_boundary),
        .ei_exec        (ei_exec),
        .di_exec        (di_exec),
        .reti_exec      (reti_exec),
        .halt_exec      (halt_exec),
        .isr_ack        (isr_ack),
        .isr_cmd        (isr_cmd),
        .isr_vector     (isr_vector),
        .ime            (ime),
        .halted         (halted),
        .halt_bug       (halt_bug)
    );

`ifdef GB_CPU_HALT_BUG_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] IB = 6'b100000;
    localparam logic [5:0] EI = 6'b010000;
    localparam logic [5:0] DI = 6'b001000;
    localparam logic [5:0] RT = 6'b000100;
    localparam logic [5:0] HL = 6'b000010;
    localparam logic [5:0] AK = 6'b000001;

    typedef struct {
        string       name;
        bit          rst;
        logic [4:0]  irq;
        bit          iew;
        bit          ifw;
        logic [7:0]  wd;
        logic [5:0]  ctrl;
        logic [27:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [27:0] sb_exp[$];
    string       sb_name[$];
    int          checks = 0;
    int          failures = 0;

    function automatic logic [27:0] pk(input logic [7:0] e_ie, input logic [7:0] e_if,
                                       input bit e_cmd, input logic [7:0] e_vec,
                                       input bit e_ime, input bit e_halted, input bit e_hb);
        return {e_ie, e_if, e_cmd, e_vec, e_ime, e_halted, e_hb};
    endfunction

    task automatic add(input string n, input bit r, input logic [4:0] irq, input bit iew,
                       input bit ifw, input logic [7:0] wd, input logic [5:0] ctrl,
                       input logic [27:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.irq = irq; v.iew = iew; v.ifw = ifw;
        v.wd = wd; v.ctrl = ctrl; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Priority: lowest pending bit picked, vector 0x50, only that IF bit cleared
        add("p_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("p_ie",   0, 5'h00, 1, 0, 8'h1F, NO, pk(8'h1F, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("p_reti", 0, 5'h00, 0, 0, 8'h00, RT, pk(8'h1F, 8'hE0, 0, 8'h00, 1, 0, 0));
        add("p_irq",  0, 5'h14, 0, 0, 8'h00, NO, pk(8'h1F, 8'hF4, 0, 8'h00, 1, 0, 0));
        add("p_bnd",  0, 5'h00, 0, 0, 8'h00, IB, pk(8'h1F, 8'hF4, 1, 8'h00, 0, 0, 0));
        add("p_wait", 0, 5'h00, 0, 0, 8'h00, NO, pk(8'h1F, 8'hF4, 1, 8'h00, 0, 0, 0));
        add("p_ack",  0, 5'h00, 0, 0, 8'h00, AK, pk(8'h1F, 8'hF0, 0, 8'h50, 0, 0, 0));
        add("p_hold", 0, 5'h00, 0, 0, 8'h00, IB, pk(8'h1F, 8'hF0, 0, 8'h50, 0, 0, 0));
        // EI delay: dispatch at the following boundary, not at EI's own
        add("e_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("e_ie",   0, 5'h00, 1, 0, 8'h01, NO, pk(8'h01, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("e_if",   0, 5'h00, 0, 1, 8'h01, NO, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("e_ei",   0, 5'h00, 0, 0, 8'h00, IB | EI, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("e_nop",  0, 5'h00, 0, 0, 8'h00, IB, pk(8'h01, 8'hE1, 1, 8'h00, 0, 0, 0));
        add("e_ack",  0, 5'h00, 0, 0, 8'h00, AK, pk(8'h01, 8'hE0, 0, 8'h40, 0, 0, 0));
        // DI between EI and the next boundary cancels the dispatch
        add("d_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("d_ie",   0, 5'h00, 1, 0, 8'h01, NO, pk(8'h01, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("d_if",   0, 5'h00, 0, 1, 8'h01, NO, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_ei",   0, 5'h00, 0, 0, 8'h00, IB | EI, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_di",   0, 5'h00, 0, 0, 8'h00, DI, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_nop",  0, 5'h00, 0, 0, 8'h00, IB, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_eidi", 0, 5'h00, 0, 0, 8'h00, IB | EI | DI, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_nop2", 0, 5'h00, 0, 0, 8'h00, IB, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_ie0",  0, 5'h00, 1, 0, 8'h00, NO, pk(8'h00, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_ei2",  0, 5'h00, 0, 0, 8'h00, IB | EI, pk(8'h00, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("d_ime",  0, 5'h00, 0, 0, 8'h00, IB, pk(8'h00, 8'hE1, 0, 8'h00, 1, 0, 0));
        add("d_di2",  0, 5'h00, 0, 0, 8'h00, DI, pk(8'h00, 8'hE1, 0, 8'h00, 0, 0, 0));
        // Halt wake with ime=0: leaves HALT one cycle after IF is set, no dispatch
        add("h_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("h_ie",   0, 5'h00, 1, 0, 8'h04, NO, pk(8'h04, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("h_halt", 0, 5'h00, 0, 0, 8'h00, IB | HL, pk(8'h04, 8'hE0, 0, 8'h00, 0, 1, 0));
        add("h_idle", 0, 5'h00, 0, 0, 8'h00, NO, pk(8'h04, 8'hE0, 0, 8'h00, 0, 1, 0));
        add("h_irq",  0, 5'h04, 0, 0, 8'h00, NO, pk(8'h04, 8'hE4, 0, 8'h00, 0, 1, 0));
        add("h_wake", 0, 5'h00, 0, 0, 8'h00, NO, pk(8'h04, 8'hE4, 0, 8'h00, 0, 0, 0));
        // Halt wake with ime=1: disabled source does not wake, enabled one dispatches
        add("w_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("w_ie",   0, 5'h00, 1, 0, 8'h04, NO, pk(8'h04, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("w_reti", 0, 5'h00, 0, 0, 8'h00, RT, pk(8'h04, 8'hE0, 0, 8'h00, 1, 0, 0));
        add("w_halt", 0, 5'h00, 0, 0, 8'h00, IB | HL, pk(8'h04, 8'hE0, 0, 8'h00, 1, 1, 0));
        add("w_irq0", 0, 5'h01, 0, 0, 8'h00, NO, pk(8'h04, 8'hE1, 0, 8'h00, 1, 1, 0));
        add("w_stay", 0, 5'h00, 0, 0, 8'h00, NO, pk(8'h04, 8'hE1, 0, 8'h00, 1, 1, 0));
        add("w_irq2", 0, 5'h04, 0, 0, 8'h00, NO, pk(8'h04, 8'hE5, 0, 8'h00, 1, 1, 0));
        add("w_disp", 0, 5'h00, 0, 0, 8'h00, NO, pk(8'h04, 8'hE5, 1, 8'h00, 0, 0, 0));
        add("w_ack",  0, 5'h00, 0, 0, 8'h00, AK, pk(8'h04, 8'hE1, 0, 8'h50, 0, 0, 0));
        // Halt bug: ime=0 with an already pending interrupt
        add("b_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("b_ie",   0, 5'h00, 1, 0, 8'h02, NO, pk(8'h02, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("b_if",   0, 5'h00, 0, 1, 8'h02, NO, pk(8'h02, 8'hE2, 0, 8'h00, 0, 0, 0));
        add("b_halt", 0, 5'h00, 0, 0, 8'h00, IB | HL, pk(8'h02, 8'hE2, 0, 8'h00, 0, 0, HB));
        add("b_post", 0, 5'h00, 0, 0, 8'h00, NO, pk(8'h02, 8'hE2, 0, 8'h00, 0, 0, 0));
        // Dispatch beats HALT on the same boundary; later HALT with nothing pending halts
        add("x_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("x_ie",   0, 5'h00, 1, 0, 8'h01, NO, pk(8'h01, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("x_if",   0, 5'h00, 0, 1, 8'h01, NO, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("x_reti", 0, 5'h00, 0, 0, 8'h00, RT, pk(8'h01, 8'hE1, 0, 8'h00, 1, 0, 0));
        add("x_both", 0, 5'h00, 0, 0, 8'h00, IB | HL, pk(8'h01, 8'hE1, 1, 8'h00, 0, 0, 0));
        add("x_ack",  0, 5'h00, 0, 0, 8'h00, AK, pk(8'h01, 8'hE0, 0, 8'h40, 0, 0, 0));
        add("x_halt", 0, 5'h00, 0, 0, 8'h00, IB | HL, pk(8'h01, 8'hE0, 0, 8'h40, 0, 1, 0));
        // Ack cancel: IE cleared mid-push gives vector 0x00 and leaves IF alone
        add("c_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("c_ie",   0, 5'h00, 1, 0, 8'h03, NO, pk(8'h03, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("c_if",   0, 5'h00, 0, 1, 8'h03, NO, pk(8'h03, 8'hE3, 0, 8'h00, 0, 0, 0));
        add("c_reti", 0, 5'h00, 0, 0, 8'h00, RT, pk(8'h03, 8'hE3, 0, 8'h00, 1, 0, 0));
        add("c_bnd",  0, 5'h00, 0, 0, 8'h00, IB, pk(8'h03, 8'hE3, 1, 8'h00, 0, 0, 0));
        add("c_ack",  0, 5'h00, 0, 0, 8'h00, AK, pk(8'h03, 8'hE2, 0, 8'h40, 0, 0, 0));
        add("c_ret2", 0, 5'h00, 0, 0, 8'h00, RT, pk(8'h03, 8'hE2, 0, 8'h40, 1, 0, 0));
        add("c_bnd2", 0, 5'h00, 0, 0, 8'h00, IB, pk(8'h03, 8'hE2, 1, 8'h40, 0, 0, 0));
        add("c_ie0",  0, 5'h00, 1, 0, 8'h00, NO, pk(8'h00, 8'hE2, 1, 8'h40, 0, 0, 0));
        add("c_ack2", 0, 5'h00, 0, 0, 8'h00, AK, pk(8'h00, 8'hE2, 0, 8'h00, 0, 0, 0));
        // Collisions: new request on the bit being cleared or written stays set
        add("k_rst",  1, 5'h00, 0, 0, 8'h00, NO, pk(8'h00, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("k_ie",   0, 5'h00, 1, 0, 8'h01, NO, pk(8'h01, 8'hE0, 0, 8'h00, 0, 0, 0));
        add("k_if",   0, 5'h00, 0, 1, 8'h01, NO, pk(8'h01, 8'hE1, 0, 8'h00, 0, 0, 0));
        add("k_reti", 0, 5'h00, 0, 0, 8'h00, RT, pk(8'h01, 8'hE1, 0, 8'h00, 1, 0, 0));
        add("k_bnd",  0, 5'h00, 0, 0, 8'h00, IB, pk(8'h01, 8'hE1, 1, 8'h00, 0, 0, 0));
        add("k_ack",  0, 5'h01, 0, 0, 8'h00, AK, pk(8'h01, 8'hE1, 0, 8'h40, 0, 0, 0));
        add("k_wr",   0, 5'h01, 0, 1, 8'h00, NO, pk(8'h01, 8'hE1, 0, 8'h40, 0, 0, 0));
        add("k_wr0",  0, 5'h00, 0, 1, 8'h00, NO, pk(8'h01, 8'hE0, 0, 8'h40, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n     = !tbl[i].rst;
            irq_req   = tbl[i].irq;
            ie_we     = tbl[i].iew;
            if_we     = tbl[i].ifw;
            reg_wdata = tbl[i].wd;
            {instr_boundary, ei_exec, di_exec, reti_exec, halt_exec, isr_ack} = tbl[i].ctrl;
            sb_exp.push_back(tbl[i].exp);
            sb_name.push_back(tbl[i].name);
            step();
            check(sb_name.pop_front(),
                  32'({ie_rdata, if_rdata, isr_cmd, isr_vector, ime, halted, halt_bug}),
                  32'(sb_exp.pop_front()));
        end

        // Asynchronous reset in the middle of DISPATCH, observed between clock edges
        irq_req = '0; ie_we = 1'b0; if_we = 1'b0;
        {instr_boundary, ei_exec, di_exec, reti_exec, halt_exec, isr_ack} = NO;
        rst_n = 1'b1;
        ie_we = 1'b1; reg_wdata = 8'h1F; step();
        ie_we = 1'b0; if_we = 1'b1; reg_wdata = 8'h1F; step();
        if_we = 1'b0; reti_exec = 1'b1; step();
        reti_exec = 1'b0; instr_boundary = 1'b1; step();
        instr_boundary = 1'b0;
        check("ar_pre", 32'({ie_rdata, if_rdata, isr_cmd}), 32'({8'h1F, 8'hFF, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_now", 32'({ie_rdata, if_rdata, isr_cmd, isr_vector, ime, halted}),
              32'({8'h00, 8'hE0, 1'b0, 8'h00, 1'b0, 1'b0}));
        step();
        rst_n = 1'b1;
        step();
        check("ar_post", 32'({ie_rdata, if_rdata, isr_cmd}), 32'({8'h00, 8'hE0, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
